// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS-style register bank.
package mips_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/registers_bank_if.sv
// Decode/writeback-side bus of the register bank: two read ports, one write port, soft clear.
interface registers_bank_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              reg_write;
  logic              clear_req;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy;
  logic              clear_done;

  modport master (
    output rd_addr1, rd_addr2, wr_addr, wr_data, reg_write, clear_req,
    input  rd_data1, rd_data2, busy, clear_done
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_addr, wr_data, reg_write, clear_req,
    output rd_data1, rd_data2, busy, clear_done
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: busy / zero-register / range gating, then bypass, then storage.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DEPTH    = 2 ** ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic                          busy_i,
  input  logic                          wr_ok_i,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  logic addr_zero;
  logic addr_ok;

  assign addr_zero = (ZERO_REG != 0) && (addr_i == ADDR_W'(ZERO_ADDR));
  assign addr_ok   = 32'(addr_i) < DEPTH;

  always_comb begin
    rd_data_o = '0;
    if (busy_i || addr_zero || !addr_ok) begin
      rd_data_o = '0;
    end else if ((BYPASS != 0) && wr_ok_i && (addr_i == wr_addr_i)) begin
      rd_data_o = wr_data_i;
    end else begin
      // Loop compare avoids index-width issues when DEPTH is not a power of two.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_i == ADDR_W'(i)) begin
          rd_data_o = mem_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/registers_bank.sv
// Parametrised register file with synchronous writes, dual combinational reads and a
// soft-clear sequencer that zeroes one entry per cycle.
module registers_bank
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DEPTH    = 2 ** ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic             clk,
  input logic             reset,
  registers_bank_if.slave bus
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  rf_state_t                    state_q, state_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic                         busy;
  logic                         addr_ok;
  logic                         addr_zero;
  logic                         write_ok;

  assign busy      = (state_q == CLEAR);
  assign addr_ok   = 32'(bus.wr_addr) < DEPTH;
  assign addr_zero = (ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_ADDR));
  assign write_ok  = bus.reg_write && !busy && addr_ok && !addr_zero;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        // Explicit end compare so a full 2**ADDR_W sweep never relies on wrap-around.
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (busy && (ptr_q == ADDR_W'(i))) begin
        mem_d[i] = '0;
      end else if (write_ok && (bus.wr_addr == ADDR_W'(i))) begin
        mem_d[i] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.clear_done = (state_q == DONE);

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_port1 (
    .addr_i   (bus.rd_addr1),
    .mem_i    (mem_q),
    .busy_i   (busy),
    .wr_ok_i  (write_ok),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .rd_data_o(bus.rd_data1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_port2 (
    .addr_i   (bus.rd_addr2),
    .mem_i    (mem_q),
    .busy_i   (busy),
    .wr_ok_i  (write_ok),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .rd_data_o(bus.rd_data2)
  );

endmodule

// File: tb/tb_registers_bank.sv
// Directed bench for registers_bank: default, no-bypass and small (16b/3b/6-deep) instances.
module tb_registers_bank;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  registers_bank_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  registers_bank_if #(.DATA_W(32), .ADDR_W(5)) ib ();
  registers_bank_if #(.DATA_W(16), .ADDR_W(3)) ic ();

  registers_bank #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)
  ) u_a (.clk(clk), .reset(reset), .bus(ia));

  registers_bank #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)
  ) u_b (.clk(clk), .reset(reset), .bus(ib));

  registers_bank #(
    .DATA_W(16), .ADDR_W(3), .DEPTH(6), .ZERO_REG(1), .BYPASS(1)
  ) u_c (.clk(clk), .reset(reset), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ia.rd_addr1 = '0; ia.rd_addr2 = '0; ia.wr_addr = '0; ia.wr_data = '0;
    ia.reg_write = 1'b0; ia.clear_req = 1'b0;
    ib.rd_addr1 = '0; ib.rd_addr2 = '0; ib.wr_addr = '0; ib.wr_data = '0;
    ib.reg_write = 1'b0; ib.clear_req = 1'b0;
    ic.rd_addr1 = '0; ic.rd_addr2 = '0; ic.wr_addr = '0; ic.wr_data = '0;
    ic.reg_write = 1'b0; ic.clear_req = 1'b0;

    // Reset asserted mid-cycle; reads are zero immediately.
    #1 reset = 1'b1;
    ia.rd_addr1 = 5'd0;
    ia.rd_addr2 = 5'd5;
    #2;
    chk("rst_rd1_a0", ia.rd_data1, 32'h0);
    chk("rst_rd2_a5", ia.rd_data2, 32'h0);
    chk("rst_busy", 32'(ia.busy), 32'h0);
    chk("rst_done", 32'(ia.clear_done), 32'h0);
    ia.rd_addr1 = 5'd31;
    #1;
    chk("rst_rd1_a31", ia.rd_data1, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Write then read back one cycle later.
    ia.rd_addr1 = 5'd0;
    ia.reg_write = 1'b1; ia.wr_addr = 5'd8; ia.wr_data = 32'hDEAD_BEEF;
    tick();
    ia.reg_write = 1'b0;
    ia.rd_addr1 = 5'd8;
    #1;
    chk("wr_rd_a8", ia.rd_data1, 32'hDEAD_BEEF);

    // Writes to the zero register are ignored, even through bypass.
    ia.reg_write = 1'b1; ia.wr_addr = 5'd0; ia.wr_data = 32'h1234_5678;
    ia.rd_addr2 = 5'd0;
    #1;
    chk("zero_bypass", ia.rd_data2, 32'h0);
    tick();
    ia.reg_write = 1'b0;
    #1;
    chk("zero_after", ia.rd_data2, 32'h0);

    // Same-cycle bypass; BYPASS=0 instance shows the old value until the edge.
    ia.reg_write = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 32'hA5A5_A5A5;
    ia.rd_addr1 = 5'd9; ia.rd_addr2 = 5'd9;
    ib.reg_write = 1'b1; ib.wr_addr = 5'd9; ib.wr_data = 32'hA5A5_A5A5;
    ib.rd_addr1 = 5'd9; ib.rd_addr2 = 5'd9;
    #1;
    chk("byp_rd1", ia.rd_data1, 32'hA5A5_A5A5);
    chk("byp_rd2", ia.rd_data2, 32'hA5A5_A5A5);
    chk("nobyp_rd1", ib.rd_data1, 32'h0);
    chk("nobyp_rd2", ib.rd_data2, 32'h0);
    tick();
    ia.reg_write = 1'b0;
    ib.reg_write = 1'b0;
    #1;
    chk("nobyp_after", ib.rd_data1, 32'hA5A5_A5A5);

    // Fill 1..31 with addr*0x11.
    ia.rd_addr1 = 5'd0; ia.rd_addr2 = 5'd0;
    for (int i = 1; i < 32; i++) begin
      ia.reg_write = 1'b1;
      ia.wr_addr   = 5'(i);
      ia.wr_data   = 32'(i) * 32'h11;
      tick();
    end
    ia.reg_write = 1'b0;
    ia.rd_addr1 = 5'd8; ia.rd_addr2 = 5'd31;
    #1;
    chk("fill_a8", ia.rd_data1, 32'h88);
    chk("fill_a31", ia.rd_data2, 32'h20F);

    // Clear request together with a write to addr 4.
    ia.clear_req = 1'b1;
    ia.reg_write = 1'b1; ia.wr_addr = 5'd4; ia.wr_data = 32'h77;
    tick();
    ia.clear_req = 1'b0;
    ia.reg_write = 1'b0;
    ia.rd_addr1 = 5'd3;
    chk("clr_busy_first", 32'(ia.busy), 32'h1);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (ia.busy) busy_cnt++;
      if (ia.clear_done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (cyc == 5) begin
        ia.reg_write = 1'b1; ia.wr_addr = 5'd3; ia.wr_data = 32'h33;
        #1;
        chk("clr_busy_read", ia.rd_data1, 32'h0);
      end else begin
        ia.reg_write = 1'b0;
      end
      tick();
    end
    ia.reg_write = 1'b0;
    chk("clr_busy_cnt", 32'(busy_cnt), 32'd32);
    chk("clr_done_cnt", 32'(done_cnt), 32'd1);
    chk("clr_done_at", 32'(done_at), 32'd33);
    for (int i = 0; i < 32; i++) begin
      ia.rd_addr1 = 5'(i);
      ia.rd_addr2 = 5'(31 - i);
      #1;
      chk($sformatf("clr_rd1_a%0d", i), ia.rd_data1, 32'h0);
      chk($sformatf("clr_rd2_a%0d", 31 - i), ia.rd_data2, 32'h0);
    end

    // Reset at clear cycle 10.
    ia.reg_write = 1'b1; ia.wr_addr = 5'd12; ia.wr_data = 32'hCC;
    tick();
    ia.wr_addr = 5'd30; ia.wr_data = 32'h1E1E;
    tick();
    ia.reg_write = 1'b0;
    ia.rd_addr1 = 5'd12; ia.rd_addr2 = 5'd30;
    #1;
    chk("pre_rst_a12", ia.rd_data1, 32'hCC);
    ia.clear_req = 1'b1;
    tick();
    ia.clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("midclr_busy", 32'(ia.busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(ia.busy), 32'h0);
    chk("midrst_done", 32'(ia.clear_done), 32'h0);
    chk("midrst_a12", ia.rd_data1, 32'h0);
    chk("midrst_a30", ia.rd_data2, 32'h0);
    tick();
    reset = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ia.busy) busy_cnt++;
      if (ia.clear_done) done_cnt++;
      tick();
    end
    chk("postrst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("postrst_done_cnt", 32'(done_cnt), 32'd0);
    chk("postrst_a12", ia.rd_data1, 32'h0);
    chk("postrst_a30", ia.rd_data2, 32'h0);

    // Small instance: DEPTH=6 with 3-bit addresses.
    ic.reg_write = 1'b1;
    ic.wr_addr = 3'd5; ic.wr_data = 16'hBEEF;
    tick();
    ic.wr_addr = 3'd6; ic.wr_data = 16'h1111;
    ic.rd_addr1 = 3'd6;
    #1;
    chk("c_byp_oor_a6", 32'(ic.rd_data1), 32'h0);
    tick();
    ic.wr_addr = 3'd7; ic.wr_data = 16'h2222;
    tick();
    ic.reg_write = 1'b0;
    ic.rd_addr1 = 3'd5; ic.rd_addr2 = 3'd6;
    #1;
    chk("c_a5", 32'(ic.rd_data1), 32'hBEEF);
    chk("c_a6", 32'(ic.rd_data2), 32'h0);
    ic.rd_addr2 = 3'd7;
    #1;
    chk("c_a7", 32'(ic.rd_data2), 32'h0);
    ic.clear_req = 1'b1;
    tick();
    ic.clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (ic.busy) busy_cnt++;
      if (ic.clear_done) begin
        done_cnt++;
        done_at = cyc;
      end
      tick();
    end
    chk("c_busy_cnt", 32'(busy_cnt), 32'd6);
    chk("c_done_cnt", 32'(done_cnt), 32'd1);
    chk("c_done_at", 32'(done_at), 32'd7);
    chk("c_a5_cleared", 32'(ic.rd_data1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registers_bank.md
Name: registers_bank

Overview:
Parametrised, clocked successor to the MIPS-32 register file.
- Provides synchronous writes, combinational dual reads and an optional hardwired zero register.
- Provides optional write-to-read bypass so a value written in the WB stage is visible in the same cycle's ID read.
- A soft-clear sequencer zeroes the whole bank over DEPTH cycles without asserting reset.
- Sits between the decode stage (read ports) and the writeback mux (write port).

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width.
- DEPTH, 2**ADDR_W, number of registers; must be ≤ 2**ADDR_W and ≥ 2.
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- rd_addr1, input, ADDR_W, read port 1 address.
- rd_addr2, input, ADDR_W, read port 2 address.
- wr_addr, input, ADDR_W, write address.
- wr_data, input, DATA_W, write data.
- reg_write, input, 1, write enable.
- clear_req, input, 1, request soft clear; level-sampled in IDLE.
- rd_data1, output, DATA_W, read port 1 data (combinational).
- rd_data2, output, DATA_W, read port 2 data (combinational).
- busy, output, 1, high while the clear sequencer runs.
- clear_done, output, 1, one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous, active-high): all DEPTH entries are set to 0, FSM goes to IDLE, clear pointer is set to 0, busy=0, clear_done=0. rd_data* reflect zeroed contents immediately.
- Write qualification: write_ok = reg_write & ~busy & (wr_addr < DEPTH) & ~(ZERO_REG & wr_addr==0).
- Write timing: on a rising clk with write_ok, entry[wr_addr] <= wr_data. Latency is 1 cycle without bypass. A disqualified write is silently dropped; no error flag.
- Read, priority order per port:
  1. If busy, the port returns 0.
  2. If ZERO_REG and the address is 0, the port returns 0.
  3. If the address ≥ DEPTH, the port returns 0.
  4. If BYPASS, write_ok and rd_addr==wr_addr, the port returns wr_data.
  5. Otherwise the port returns entry[rd_addr].
- Both ports are independent. Both may read the same address, including during a bypass.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: busy=0. clear_req=1 moves to CLEAR with ptr=0. A write in that same cycle is still performed and is then zeroed by the sweep.
  - CLEAR: busy=1. Each cycle entry[ptr] <= 0 and ptr increments. When ptr==DEPTH-1, that entry is cleared and the FSM moves to DONE. clear_req is ignored; writes are dropped.
  - DONE: busy=0, clear_done=1 for exactly one cycle, then IDLE. Writes are accepted in DONE. clear_req in DONE is honoured on the next IDLE cycle only.
- Clear latency: clear_req sampled at edge N gives busy high for cycles N+1 through N+DEPTH, and clear_done high in cycle N+DEPTH+1.
- Pointer width: ptr is ADDR_W bits. A full 2**ADDR_W sweep must not overflow the DONE test; compare with DEPTH-1 rather than wrapping to 0.
- Reset mid-CLEAR: the bank is zeroed at once, FSM goes to IDLE, and clear_done is not pulsed.
- No read-modify-write, no byte enables. Storage is inferable as flops; reset clear of the array is mandatory.

Decomposition:
- Shared package mips_pkg holds:
  - the FSM state typedef rf_state_t {IDLE, CLEAR, DONE};
  - localparam defaults REG_DATA_W=32 and REG_ADDR_W=5;
  - constant ZERO_ADDR = '0.
- One natural sub-module: rf_read_port, instantiated twice. It takes an address, the array view, busy and the bypass inputs, and implements the read priority mux. Storage and FSM stay in the top level.

Test Plan:
- Reset then read: assert reset mid-cycle, read addresses 0, 5, 31 -> rd_data1/2 = 0 immediately, busy=0.
- Write/readback: write 0xDEADBEEF to addr 8 at edge k, read addr 8 at cycle k+1 -> 0xDEADBEEF. Then write 0x12345678 to addr 0 -> addr 0 still reads 0 (ZERO_REG=1).
- Bypass: in the same cycle, reg_write=1, wr_addr=9, wr_data=0xA5A5A5A5, rd_addr1=rd_addr2=9 -> both ports return 0xA5A5A5A5 combinationally. With BYPASS=0 they return the old value (0).
- Soft clear: fill addrs 1..31 with addr*0x11, pulse clear_req -> busy high exactly 32 cycles, clear_done a single pulse at cycle 33, all reads 0 afterwards. A write to addr 3 attempted mid-clear is dropped (reads 0).
- Simultaneous events: clear_req and a write of 0x77 to addr 4 in the same IDLE cycle -> addr 4 reads 0 after clear_done. Separately, assert reset at clear cycle 10 -> busy=0 at once, no clear_done pulse, all entries 0.
- Parametrisation: DATA_W=16, ADDR_W=3, DEPTH=6 -> writes to addrs 6/7 are dropped and read 0, clear busy lasts 6 cycles, addr 5 reads back 0xBEEF.
